// File: rtl/clk_period_meter.sv
// Measures the period and high time of a slow, asynchronous signal in clk cycles.
// A stalled or lost input is flagged once no rising edge arrives within TIMEOUT cycles.
module clk_period_meter #(
    parameter int CNT_W       = 26,
    parameter int TIMEOUT     = 2048,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             lost
);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    state_t                 state_reg;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   s_d_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [CNT_W-1:0]       high_cnt_reg;
    logic [CNT_W-1:0]       period_reg;
    logic [CNT_W-1:0]       high_time_reg;
    logic                   meas_valid_reg;
    logic                   locked_reg;
    logic                   lost_reg;

    logic s;
    logic rise;

    assign s    = sync_reg[SYNC_STAGES-1];
    assign rise = s & ~s_d_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
            s_d_reg  <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], sig_in};
            s_d_reg  <= s;
        end
    end

    // The rise cycle itself is counted as cycle 1 of the new window, so a
    // window closed by the next rise reports exactly the edge-to-edge distance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            high_cnt_reg   <= '0;
            period_reg     <= '0;
            high_time_reg  <= '0;
            meas_valid_reg <= 1'b0;
            locked_reg     <= 1'b0;
            lost_reg       <= 1'b0;
        end else begin
            meas_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    cnt_reg      <= '0;
                    high_cnt_reg <= '0;
                    if (rise) begin
                        cnt_reg      <= ONE_C;
                        high_cnt_reg <= ONE_C;
                        state_reg    <= MEASURE;
                    end
                end
                MEASURE: begin
                    // An edge on the timeout cycle still wins, so cnt never passes TIMEOUT.
                    if (rise) begin
                        period_reg     <= cnt_reg;
                        high_time_reg  <= high_cnt_reg;
                        meas_valid_reg <= 1'b1;
                        locked_reg     <= 1'b1;
                        lost_reg       <= 1'b0;
                        cnt_reg        <= ONE_C;
                        high_cnt_reg   <= ONE_C;
                    end else if (cnt_reg == TIMEOUT_C) begin
                        lost_reg     <= 1'b1;
                        locked_reg   <= 1'b0;
                        cnt_reg      <= '0;
                        high_cnt_reg <= '0;
                        state_reg    <= IDLE;
                    end else begin
                        cnt_reg      <= cnt_reg + ONE_C;
                        high_cnt_reg <= high_cnt_reg + {{(CNT_W-1){1'b0}}, s};
                    end
                end
            endcase
        end
    end

    assign period     = period_reg;
    assign high_time  = high_time_reg;
    assign meas_valid = meas_valid_reg;
    assign locked     = locked_reg;
    assign lost       = lost_reg;

endmodule
